seg_scan_display: RTL

//  Time-multiplexed driver for an NDIGITS common-anode 7-segment display, active-low.
//  - Shows a packed hex word, with per-digit decimal point, per-digit blank mask and

---
 rtl/seg_pkg.sv | 14 +
 rtl/seg_hex_decode.sv | 13 +
 rtl/seg_scan_display.sv | 158 +++++++++++++++
 3 files changed

// File: rtl/seg_pkg.sv
// Shared types and the active-low seven-segment glyph table for the scan display.
package seg_pkg;

    typedef logic [3:0] hex_t;

    localparam logic [6:0] SEG_OFF = 7'h7F;

    // gfedcba, active-low, for hex digits 0..F
    localparam logic [6:0] SEG_HEX [16] = '{
        7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
        7'h00, 7'h18, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E
    };

endpackage

// File: rtl/seg_hex_decode.sv
// Combinational hex digit to active-low gfedcba segment pattern.
module seg_hex_decode
    import seg_pkg::*;
(
    input  hex_t       i_hex,
    output logic [6:0] o_seg
);

    always_comb begin
        o_seg = SEG_HEX[i_hex];
    end

endmodule

// File: rtl/seg_scan_display.sv
// Time-multiplexed common-anode 7-segment driver with double-buffered display data,
// per-digit dp/blank, leading-zero suppression and dead-time between digit slots.
module seg_scan_display
    import seg_pkg::*;
#(
    parameter int NDIGITS     = 4,
    parameter int REFRESH_DIV = 1024,
    parameter int DEAD_CYCLES = 2
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   load,
    input  logic [4*NDIGITS-1:0]   value,
    input  logic [NDIGITS-1:0]     dp_in,
    input  logic [NDIGITS-1:0]     blank_in,
    input  logic                   lzs,
    output logic                   pending,
    output logic                   frame_start,
    output logic [NDIGITS-1:0]     an,
    output logic [6:0]             seg,
    output logic                   dp
);

    localparam int CW = $clog2(REFRESH_DIV);
    localparam int IW = (NDIGITS > 1) ? $clog2(NDIGITS) : 1;
    localparam logic [CW-1:0] CNT_LAST = CW'(REFRESH_DIV - 1);
    localparam logic [IW-1:0] IDX_LAST = IW'(NDIGITS - 1);
    localparam logic [CW:0]   DEAD_W   = (CW + 1)'(DEAD_CYCLES);

    logic [CW-1:0]          r_cnt;
    logic [IW-1:0]          r_idx;

    logic [4*NDIGITS-1:0]   r_pend_val;
    logic [NDIGITS-1:0]     r_pend_dp;
    logic [NDIGITS-1:0]     r_pend_blank;
    logic                   r_pend_lzs;
    logic                   r_pending;

    logic [4*NDIGITS-1:0]   r_disp_val;
    logic [NDIGITS-1:0]     r_disp_dp;
    logic [NDIGITS-1:0]     r_disp_blank;
    logic                   r_disp_lzs;

    logic                   w_slot_end;
    logic                   w_frame_end;
    logic                   w_dead;
    logic [NDIGITS-1:0]     w_lz_mask;
    logic [NDIGITS-1:0]     w_an_sel;
    hex_t                   w_digit;
    logic                   w_dp_bit;
    logic                   w_blank_bit;
    logic                   w_lz_bit;
    logic [6:0]             w_dec;

    assign w_slot_end  = (r_cnt == CNT_LAST);
    assign w_frame_end = w_slot_end && (r_idx == IDX_LAST);
    assign w_dead      = (DEAD_CYCLES != 0) && ({1'b0, r_cnt} < DEAD_W);
    assign w_an_sel    = NDIGITS'(1) << r_idx;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_cnt <= '0;
            r_idx <= '0;
        end else if (w_slot_end) begin
            r_cnt <= '0;
            r_idx <= (r_idx == IDX_LAST) ? '0 : r_idx + 1'b1;
        end else begin
            r_cnt <= r_cnt + 1'b1;
        end
    end

    // A load coinciding with the frame transfer lands in the pending bank after the
    // old pending contents were copied, so pending stays set for one more frame.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_pend_val   <= '0;
            r_pend_dp    <= '0;
            r_pend_blank <= '0;
            r_pend_lzs   <= 1'b0;
            r_pending    <= 1'b0;
            r_disp_val   <= '0;
            r_disp_dp    <= '0;
            r_disp_blank <= '0;
            r_disp_lzs   <= 1'b0;
        end else begin
            if (load) begin
                r_pend_val   <= value;
                r_pend_dp    <= dp_in;
                r_pend_blank <= blank_in;
                r_pend_lzs   <= lzs;
            end
            if (w_frame_end && r_pending) begin
                r_disp_val   <= r_pend_val;
                r_disp_dp    <= r_pend_dp;
                r_disp_blank <= r_pend_blank;
                r_disp_lzs   <= r_pend_lzs;
            end
            if (load)
                r_pending <= 1'b1;
            else if (w_frame_end)
                r_pending <= 1'b0;
        end
    end

    // Suppression runs from the most significant digit down and stops at the first nonzero.
    always_comb begin
        logic run;
        w_lz_mask = '0;
        run       = r_disp_lzs;
        for (int i = NDIGITS - 1; i >= 1; i--) begin
            run          = run && (r_disp_val[4*i +: 4] == 4'h0);
            w_lz_mask[i] = run;
        end
    end

    always_comb begin
        w_digit     = '0;
        w_dp_bit    = 1'b0;
        w_blank_bit = 1'b0;
        w_lz_bit    = 1'b0;
        for (int i = 0; i < NDIGITS; i++) begin
            if (r_idx == IW'(i)) begin
                w_digit     = r_disp_val[4*i +: 4];
                w_dp_bit    = r_disp_dp[i];
                w_blank_bit = r_disp_blank[i];
                w_lz_bit    = w_lz_mask[i];
            end
        end
    end

    seg_hex_decode u_dec (
        .i_hex (w_digit),
        .o_seg (w_dec)
    );

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            an          <= '1;
            seg         <= SEG_OFF;
            dp          <= 1'b1;
            frame_start <= 1'b0;
        end else begin
            frame_start <= w_frame_end;
            if (w_dead) begin
                an  <= '1;
                seg <= SEG_OFF;
                dp  <= 1'b1;
            end else begin
                an  <= ~w_an_sel;
                seg <= (w_blank_bit || w_lz_bit) ? SEG_OFF : w_dec;
                dp  <= w_blank_bit ? 1'b1 : ~w_dp_bit;
            end
        end
    end

    assign pending = r_pending;

endmodule
